citi_sample_pacer: RTL

Upstream feeder for the citi IIR summer stage. It buffers 16-bit input samples written by a host or loader in an N-deep FIFO. It releases one sample every PERIOD clk30x cycles on xin, together with a single-cycle donext strobe, so the filter always sees a fixed sample rate. Underflow is flagged without disturbing the strobe cadence.

---
 rtl/citi_sample_pacer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/citi_sample_pacer.sv
// -----------------------------------------------------------------------------
// citi_sample_pacer
//
// Upstream feeder for the citi IIR summer stage. Samples written by a host or
// loader are buffered in an N-deep FIFO. One sample is released every PERIOD
// clk30x cycles on xin, together with a single-cycle donext strobe, so the
// filter always sees a fixed sample rate. If the FIFO is empty when a strobe
// falls due, the strobe still fires and underflow pulses with it.
//
// Build option:
//   PACER_HOLD_LAST_EN  defined     -> on underflow xin keeps the last sample
//                       not defined -> on underflow xin is forced to zero
//
// Ports:
//   clk30x     in   1     system clock, rising edge
//   rst        in   1     synchronous, active-high reset
//   wr_en      in   1     push wr_data when the FIFO is not full
//   wr_data    in   W     sample to push (two's complement, passed bit-exact)
//   full       out  1     FIFO holds N entries
//   count      out  AW+1  current occupancy 0..N
//   enable     in   1     run the pacer; low freezes and restarts the cadence
//   xin        out  W     sample presented to the filter (registered)
//   donext     out  1     one-cycle strobe, xin is new in this cycle
//   underflow  out  1     one-cycle pulse with donext when the FIFO was empty
// -----------------------------------------------------------------------------
module citi_sample_pacer #(
  parameter int N      = 8,
  parameter int AW     = 3,
  parameter int PERIOD = 30,
  parameter int W      = 16
) (
  input  logic          clk30x,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  output logic [AW:0]   count,
  input  logic          enable,
  output logic [W-1:0]  xin,
  output logic          donext,
  output logic          underflow
);

  // Phase counter width; PERIOD is at least 2 so this is at least 1 bit.
  localparam int              CW       = $clog2(PERIOD);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
  localparam logic [AW:0]     DEPTH    = (AW + 1)'(N);

  // ---------------------------------------------------------------------------
  // Cadence
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          tick;

  always_comb begin
    cnt_next = cnt_reg;
    tick     = 1'b0;
    if (!enable) begin
      // Dropping enable restarts a full PERIOD wait on re-enable.
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      tick     = 1'b1;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty;
  logic          push;
  logic          pop;

  // Both decisions use the occupancy before the edge: an empty FIFO never
  // bypasses a same-cycle write to xin, and a full FIFO rejects a write even
  // if a pop happens in the same cycle.
  assign empty = (count_reg == '0);
  assign push  = wr_en && !full_reg;
  assign pop   = tick && !empty;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      // N is a power of two, so natural pointer overflow is the modulo-N wrap.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage (no reset, maps to RAM; read is captured into xin_reg)
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem [N];

  always_ff @(posedge clk30x) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [W-1:0] xin_reg;
  logic         donext_reg;
  logic         underflow_reg;

  always_ff @(posedge clk30x) begin
    if (rst) begin
      xin_reg       <= '0;
      donext_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (!enable) begin
      // xin holds while paused; strobes are suppressed.
      donext_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      donext_reg    <= tick;
      underflow_reg <= tick && empty;
      if (pop) begin
        xin_reg <= mem[rd_ptr_reg];
      end else if (tick) begin
`ifdef PACER_HOLD_LAST_EN
        // Zero-order hold: the filter re-reads the previous sample.
        xin_reg <= xin_reg;
`else
        // Zero insertion keeps impulse-response tests clean.
        xin_reg <= '0;
`endif
      end
    end
  end

  assign xin       = xin_reg;
  assign donext    = donext_reg;
  assign underflow = underflow_reg;
  assign count     = count_reg;
  assign full      = full_reg;

endmodule
